// File: rtl/logic_unit_arbiter.sv
// Two-requester arbiter in front of one shared 8-bit logic datapath (AND/OR/XOR/NOT).
// Define LOGIC_ARB_FIXED_PRIO_EN to give requester 0 fixed priority instead of round-robin.

module and8b (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);
  assign y = a & b;
endmodule

module or8b (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);
  assign y = a | b;
endmodule

module xor8b (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);
  assign y = a ^ b;
endmodule

module not8b (
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = ~a;
endmodule

module logic_unit_arbiter #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [1:0] req_op0,
  input  logic [1:0] req_op1,
  input  logic [7:0] req_a0,
  input  logic [7:0] req_b0,
  input  logic [7:0] req_a1,
  input  logic [7:0] req_b1,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_id,
  output logic [7:0] op_count,
  output logic       dbg_state
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  // Handshake: a request is taken when req_valid[i] & req_ready[i] (only in IDLE);
  // a result is consumed when res_valid & res_ready (only in HOLD).
  state_t     r_state;
  logic       r_ptr;
  logic       r_res_valid;
  logic [7:0] r_res_data;
  logic       r_res_id;
  logic [7:0] r_op_count;

  logic       w_any;
  logic       w_fire;
  logic       w_gnt_id;
  logic [1:0] w_op;
  logic [7:0] w_a;
  logic [7:0] w_b;
  logic [7:0] w_and;
  logic [7:0] w_or;
  logic [7:0] w_xor;
  logic [7:0] w_not;
  logic [7:0] w_res;

  assign w_any = |req_valid;

  always_comb begin
    w_gnt_id = 1'b0;
`ifdef LOGIC_ARB_FIXED_PRIO_EN
    w_gnt_id = ~req_valid[0];
`else
    // Pointer only matters on contention; a lone requester always wins.
    if (req_valid == 2'b11) w_gnt_id = r_ptr;
    else                    w_gnt_id = req_valid[1];
`endif
  end

  assign w_fire    = (r_state == IDLE) && w_any && !rst;
  assign req_ready = w_fire ? (w_gnt_id ? 2'b10 : 2'b01) : 2'b00;

  assign w_op = w_gnt_id ? req_op1 : req_op0;
  assign w_a  = w_gnt_id ? req_a1  : req_a0;
  assign w_b  = w_gnt_id ? req_b1  : req_b0;

  and8b u_and (.a(w_a), .b(w_b), .y(w_and));
  or8b  u_or  (.a(w_a), .b(w_b), .y(w_or));
  xor8b u_xor (.a(w_a), .b(w_b), .y(w_xor));
  not8b u_not (.a(w_a), .y(w_not));

  always_comb begin
    w_res = w_and;
    case (w_op)
      2'b00:   w_res = w_and;
      2'b01:   w_res = w_or;
      2'b10:   w_res = w_xor;
      default: w_res = w_not;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= RR_INIT;
      r_res_valid <= 1'b0;
      r_res_data  <= 8'h00;
      r_res_id    <= 1'b0;
      r_op_count  <= 8'h00;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_res_data  <= w_res;
            r_res_id    <= w_gnt_id;
            r_ptr       <= ~w_gnt_id;
            r_res_valid <= 1'b1;
            r_state     <= HOLD;
          end
        end
        HOLD: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_op_count  <= r_op_count + 8'd1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;
  assign op_count  = r_op_count;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: vector table plus reset, hold, alternation and wrap sequences.
// Expectations follow LOGIC_ARB_FIXED_PRIO_EN when it is defined for the build.

module tb_logic_unit_arbiter;

`ifdef LOGIC_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [1:0] req_op0, req_op1;
  logic [7:0] req_a0, req_b0, req_a1, req_b1;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_id;
  logic [7:0] op_count;
  logic       dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_count;
  logic       exp_ptr;

  typedef struct {
    logic [1:0] valid;
    logic [1:0] op0; logic [7:0] a0; logic [7:0] b0;
    logic [1:0] op1; logic [7:0] a1; logic [7:0] b1;
    logic [7:0] d0;  logic [7:0] d1;
    logic       id_rr; logic id_fx;
  } vec_t;

  vec_t tbl[6];

  logic_unit_arbiter #(.RR_INIT(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id),
    .op_count(op_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

  task automatic run_vec(input vec_t v);
    logic       eid;
    logic [7:0] ed;
    eid = FIXED ? v.id_fx : v.id_rr;
    ed  = eid ? v.d1 : v.d0;
    req_valid = v.valid;
    req_op0 = v.op0; req_a0 = v.a0; req_b0 = v.b0;
    req_op1 = v.op1; req_a1 = v.a1; req_b1 = v.b1;
    res_ready = 1'b1;
    #1;
    chk("vec_req_ready", {6'b0, req_ready}, {6'b0, onehot(eid)});
    tick();
    exp_ptr = ~eid;
    req_valid = 2'b00;
    chk("vec_res_valid", {7'b0, res_valid}, 8'h01);
    chk("vec_res_data", res_data, ed);
    chk("vec_res_id", {7'b0, res_id}, {7'b0, eid});
    tick();
    exp_count = exp_count + 8'd1;
    chk("vec_op_count", op_count, exp_count);
  endtask

  task automatic xact0(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ed);
    req_valid = 2'b01; req_op0 = op; req_a0 = a; req_b0 = b; res_ready = 1'b1;
    tick();
    req_valid = 2'b00;
    chk("x_res_data", res_data, ed);
    tick();
    exp_count = exp_count + 8'd1;
    chk("x_op_count", op_count, exp_count);
  endtask

  initial begin
    tbl[0] = '{2'b01, 2'b00, 8'hF0, 8'h3C, 2'b00, 8'h00, 8'h00, 8'h30, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{2'b10, 2'b00, 8'h00, 8'h00, 2'b01, 8'h0F, 8'hF0, 8'h00, 8'hFF, 1'b1, 1'b1};
    tbl[2] = '{2'b11, 2'b10, 8'hFF, 8'h0F, 2'b00, 8'hFF, 8'h00, 8'hF0, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{2'b11, 2'b00, 8'hFF, 8'hFF, 2'b11, 8'hA5, 8'hFF, 8'hFF, 8'h5A, 1'b1, 1'b0};
    tbl[4] = '{2'b01, 2'b11, 8'h00, 8'h12, 2'b00, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0};
    tbl[5] = '{2'b11, 2'b01, 8'h01, 8'h02, 2'b10, 8'h3C, 8'hC3, 8'h03, 8'hFF, 1'b1, 1'b0};

    // Reset with both requesters knocking: nothing may be accepted.
    rst = 1'b1; req_valid = 2'b11; res_ready = 1'b0;
    req_op0 = 2'b00; req_op1 = 2'b00;
    req_a0 = 8'h00; req_b0 = 8'h00; req_a1 = 8'h00; req_b1 = 8'h00;
    tick();
    chk("rst_req_ready", {6'b0, req_ready}, 8'h00);
    tick();
    chk("rst_req_ready2", {6'b0, req_ready}, 8'h00);
    chk("rst_res_valid", {7'b0, res_valid}, 8'h00);
    chk("rst_res_data", res_data, 8'h00);
    chk("rst_res_id", {7'b0, res_id}, 8'h00);
    chk("rst_op_count", op_count, 8'h00);
    chk("rst_state", {7'b0, dbg_state}, 8'h00);
    rst = 1'b0; req_valid = 2'b00;
    exp_count = 8'h00; exp_ptr = 1'b0;
    tick();

    // Reset while a result is held discards it.
    req_valid = 2'b01; req_op0 = 2'b00; req_a0 = 8'hF0; req_b0 = 8'h3C; res_ready = 1'b0;
    #1;
    chk("hr_req_ready", {6'b0, req_ready}, 8'h01);
    tick();
    chk("hr_res_valid", {7'b0, res_valid}, 8'h01);
    chk("hr_res_data", res_data, 8'h30);
    tick();
    rst = 1'b1;
    #1;
    chk("hr_rst_ready", {6'b0, req_ready}, 8'h00);
    tick();
    chk("hr_res_valid0", {7'b0, res_valid}, 8'h00);
    chk("hr_res_data0", res_data, 8'h00);
    chk("hr_op_count", op_count, 8'h00);
    chk("hr_state", {7'b0, dbg_state}, 8'h00);
    rst = 1'b0; req_valid = 2'b00; exp_ptr = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // Continuous contention: alternate under round-robin, requester 0 under fixed priority.
    req_valid = 2'b11; res_ready = 1'b1;
    req_op0 = 2'b00; req_a0 = 8'hAA; req_b0 = 8'hFF;
    req_op1 = 2'b00; req_a1 = 8'h55; req_b1 = 8'hFF;
    for (int g = 0; g < 4; g++) begin
      logic eid;
      eid = FIXED ? 1'b0 : exp_ptr;
      #1;
      chk("alt_req_ready", {6'b0, req_ready}, {6'b0, onehot(eid)});
      tick();
      chk("alt_hold_ready", {6'b0, req_ready}, 8'h00);
      chk("alt_res_id", {7'b0, res_id}, {7'b0, eid});
      chk("alt_res_data", res_data, eid ? 8'h55 : 8'hAA);
      exp_ptr = ~eid;
      tick();
      exp_count = exp_count + 8'd1;
    end
    chk("alt_op_count", op_count, exp_count);

    // Back-pressure: result held stable while the other inputs churn.
    req_valid = 2'b10; req_op1 = 2'b11; req_a1 = 8'hA5; req_b1 = 8'hFF; res_ready = 1'b0;
    #1;
    chk("hold_grant", {6'b0, req_ready}, 8'h02);
    tick();
    exp_ptr = 1'b0;
    for (int c = 0; c < 5; c++) begin
      req_valid = 2'b11;
      req_op0 = 2'($urandom_range(0, 3)); req_op1 = 2'($urandom_range(0, 3));
      req_a0 = 8'($urandom_range(0, 255)); req_a1 = 8'($urandom_range(0, 255));
      req_b1 = 8'($urandom_range(0, 255));
      #1;
      chk("hold_res_valid", {7'b0, res_valid}, 8'h01);
      chk("hold_res_data", res_data, 8'h5A);
      chk("hold_res_id", {7'b0, res_id}, 8'h01);
      chk("hold_req_ready", {6'b0, req_ready}, 8'h00);
      chk("hold_op_count", op_count, exp_count);
      tick();
    end
    req_valid = 2'b00; res_ready = 1'b1;
    tick();
    exp_count = exp_count + 8'd1;
    chk("hold_done_valid", {7'b0, res_valid}, 8'h00);
    chk("hold_done_state", {7'b0, dbg_state}, 8'h00);
    chk("hold_done_count", op_count, exp_count);

    xact0(2'b10, 8'hFF, 8'h0F, 8'hF0);
    while (exp_count != 8'hFF) xact0(2'b01, 8'h0F, 8'hF0, 8'hFF);
    chk("wrap_pre", op_count, 8'hFF);
    xact0(2'b01, 8'h0F, 8'hF0, 8'hFF);
    chk("wrap_zero", op_count, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 Parameter: RR_INIT, default 0, round-robin pointer value loaded at reset (0 = requester 0 preferred first).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  2  per-requester request strobe; bit i belongs to requester i.
REQ-005 req_ready  output  2  per-requester accept; bit i high on the cycle requester i's request is taken.
REQ-006 req_op0, req_op1  input  2 each  operation code: 00 AND, 01 OR, 10 XOR, 11 NOT a.
REQ-007 req_a0, req_b0, req_a1, req_b1  input  8 each  operands per requester.
REQ-008 res_valid  output  1  result available.
REQ-009 res_ready  input  1  consumer accepts the result.
REQ-010 res_data  output  8  registered result.
REQ-011 res_id  output  1  index of the requester that produced res_data.
REQ-012 op_count  output  8  count of results consumed (res_valid & res_ready), wraps 255->0.

Function
REQ-013 Shared datapath SHALL be one instance each of and8b, or8b, xor8b, not8b, with output selection driven by the granted op code; operand b SHALL be ignored for op 11.
REQ-014 FSM states: IDLE, HOLD; reset state IDLE.
REQ-015 IDLE: if any req_valid bit is high, grant one requester, assert its req_ready bit combinationally in that cycle, register result/res_id, go to HOLD; otherwise stay IDLE with req_ready = 00.
REQ-016 HOLD: res_valid = 1, req_ready = 00; res_data and res_id SHALL stay stable until res_valid & res_ready, after which the FSM SHALL go to IDLE.
REQ-017 Latency: request accepted in cycle N, res_valid high in cycle N+1; maximum throughput one result per 2 cycles.
REQ-018 At most one req_ready bit SHALL be high in any cycle.
REQ-019 Round-robin: when both requesters are valid, grant the requester indicated by the pointer; after each grant the pointer SHALL move to the other requester; a single valid requester is always granted regardless of the pointer.
REQ-020 Operand or op changes on a non-granted requester SHALL NOT affect a held result.
REQ-021 op_count SHALL increment exactly once per consumed result, wrap 255->0, and be unaffected by requests not yet consumed.

Reset
REQ-022 With rst high at a clock edge: state IDLE, res_valid 0, res_data 00h, res_id 0, op_count 00h, pointer RR_INIT, req_ready 00 during the reset cycle.
REQ-023 Reset while in HOLD SHALL discard the pending result without incrementing op_count.
REQ-024 A request presented during reset SHALL NOT be accepted.

Configuration
REQ-025 Macro LOGIC_ARB_FIXED_PRIO_EN: when defined, requester 0 SHALL always win simultaneous requests and the pointer and RR_INIT SHALL have no effect; when undefined, round-robin per REQ-019 applies.

Verification
REQ-026 Reset, then req_valid=01, op0=00, a0=F0h, b0=3Ch, res_ready=1 -> req_ready=01 in cycle N; cycle N+1 res_valid=1, res_data=30h, res_id=0; op_count=01h afterwards.
REQ-027 Both valid continuously, res_ready=1, RR_INIT=0, macro undefined -> grants alternate 0,1,0,1; res_id sequence 0,1,0,1; one result every 2 cycles.
REQ-028 Same stimulus with LOGIC_ARB_FIXED_PRIO_EN defined -> every grant to requester 0; requester 1 never granted.
REQ-029 op1=11, a1=A5h, b1=FFh, res_ready held 0 for 5 cycles -> res_data=5Ah stable, res_valid high, req_ready=00 throughout; on res_ready=1, result consumed and FSM returns to IDLE.
REQ-030 rst asserted in HOLD (res_data=30h pending) -> next cycle res_valid=0, res_data=00h, op_count unchanged.
REQ-031 256 consumed results -> op_count wraps to 00h; op 01 with a=0Fh, b=F0h -> FFh; op 10 with a=FFh, b=0Fh -> F0h.
